// File: rtl/cic_bitstream_decimator_if.sv
// cic_bitstream_decimator_if: sigma-delta bit input and decimated sample output bundle
interface cic_bitstream_decimator_if #(parameter int OUT_W = 13);
    logic             bit_in;
    logic             bit_en;
    logic [OUT_W-1:0] sample_out;
    logic             sample_strobe;
    modport master (output bit_in, bit_en, input sample_out, sample_strobe);
    modport slave  (input bit_in, bit_en, output sample_out, sample_strobe);
endinterface

// File: rtl/cic_bitstream_decimator.sv
// cic_bitstream_decimator: 3-stage CIC decimator turning a 1-bit sigma-delta stream into signed samples (CIC_TESTRAMP_EN: ramp output)
module cic_bitstream_decimator #(
    parameter int DECIM_LOG2 = 5,
    parameter int OUT_W      = 13
) (
    input logic clk,
    input logic rst,
    cic_bitstream_decimator_if.slave bus
);
    localparam int ACC_W = 3*DECIM_LOG2+2;
    localparam int SHIFT = 3*DECIM_LOG2+1-OUT_W;
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;
    typedef enum logic [2:0] {IDLE, C1, C2, C3, OUT} state_t;
    state_t state;
    logic signed [ACC_W-1:0] i1, i2, i3, c0, c1, c2, c3, d0, d1, d2, x, sh;
    logic [DECIM_LOG2-1:0] dec_cnt;
    logic tick;
    logic [OUT_W-1:0] sat;
`ifdef CIC_TESTRAMP_EN
    logic [OUT_W-1:0] ramp;
`endif
    always_comb begin
        x    = bus.bit_in ? ACC_W'(1) : '1;
        tick = bus.bit_en && dec_cnt == '1;
        sh   = c3 >>> SHIFT;
        sat  = sh > S_MAX ? S_MAX[OUT_W-1:0] : sh < S_MIN ? S_MIN[OUT_W-1:0] : sh[OUT_W-1:0];
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state             <= IDLE;
            i1                <= '0;
            i2                <= '0;
            i3                <= '0;
            c0                <= '0;
            c1                <= '0;
            c2                <= '0;
            c3                <= '0;
            d0                <= '0;
            d1                <= '0;
            d2                <= '0;
            dec_cnt           <= '0;
            bus.sample_out    <= '0;
            bus.sample_strobe <= 1'b0;
`ifdef CIC_TESTRAMP_EN
            ramp              <= '0;
`endif
        end else begin
            bus.sample_strobe <= 1'b0;
            if (bus.bit_en) begin
                i1      <= i1 + x;
                i2      <= i2 + i1;
                i3      <= i3 + i2;
                dec_cnt <= dec_cnt + 1'b1;
            end
            // a tick outside IDLE is impossible for R >= 32 and is ignored
            case (state)
                IDLE: if (tick) begin
                    c0    <= i3;
                    state <= C1;
                end
                C1: begin
                    c1    <= c0 - d0;
                    d0    <= c0;
                    state <= C2;
                end
                C2: begin
                    c2    <= c1 - d1;
                    d1    <= c1;
                    state <= C3;
                end
                C3: begin
                    c3    <= c2 - d2;
                    d2    <= c2;
                    state <= OUT;
                end
                OUT: begin
`ifdef CIC_TESTRAMP_EN
                    bus.sample_out <= ramp;
                    ramp           <= ramp + 1'b1;
`else
                    bus.sample_out <= sat;
`endif
                    bus.sample_strobe <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_cic_bitstream_decimator.sv
// tb_cic_bitstream_decimator: scoreboard bench for the CIC decimator with hand-computed settling and steady-state samples
module tb_cic_bitstream_decimator;
    typedef struct {
        logic              chk;
        logic signed [12:0] val;
        int                cyc;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    int en_cnt = 0;
    int win = 0;
    logic suppress = 1'b0;
    logic [12:0] ramp = '0;
    logic signed [12:0] exp_tab [4];
    logic [3:0] exp_mask;
    exp_t sb[$];
    cic_bitstream_decimator_if #(.OUT_W(13)) bus ();
    cic_bitstream_decimator #(.DECIM_LOG2(5), .OUT_W(13)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, req);
        end
    endtask
    // one enabled bit per call; the bench's own counter predicts every tick
    task automatic drive(input logic b, input logic e);
        @(negedge clk);
        bus.bit_in = b;
        bus.bit_en = e;
        if (e) begin
            if (en_cnt == 31 && !suppress) begin
                int idx;
                exp_t t;
                idx = win < 3 ? win : 3;
`ifdef CIC_TESTRAMP_EN
                t = '{chk: 1'b1, val: ramp, cyc: cyc + 5};
                ramp++;
`else
                t = '{chk: exp_mask[idx], val: exp_tab[idx], cyc: cyc + 5};
`endif
                sb.push_back(t);
                win++;
            end
            en_cnt = (en_cnt + 1) % 32;
        end
    endtask
    task automatic clear_model();
        sb.delete();
        en_cnt = 0;
        win = 0;
        ramp = '0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.bit_en = 1'b0;
        bus.bit_in = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sample", int'(bus.sample_out), 0);
        check("rst_strobe", int'(bus.sample_strobe), 0);
        clear_model();
        rst = 1'b0;
    endtask
    task automatic run_test(input int pat, input logic half,
                            input logic signed [12:0] e0, input logic signed [12:0] e1,
                            input logic signed [12:0] e2, input logic signed [12:0] e3,
                            input logic [3:0] mask, input int nwin, input logic do_rst);
        if (do_rst) do_reset();
        exp_tab = '{e0, e1, e2, e3};
        exp_mask = mask;
        for (int k = 0; k < nwin*32; k++) begin
            if (half) drive(1'b0, 1'b0);
            drive(pat == 0 ? 1'b1 : pat == 1 ? 1'b0 : (k % 2 == 0), 1'b1);
        end
        repeat (10) drive(1'b0, 1'b0);
        check("drained", sb.size(), 0);
    endtask
    always @(negedge clk)
        if (!rst && bus.sample_strobe) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_strobe at cycle %0d: got strobe, required none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.chk) check("sample", int'($signed(bus.sample_out)), int'(e.val));
                check("latency", cyc, e.cyc);
            end
        end
    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end
    initial begin
        bus.bit_in = 1'b0;
        bus.bit_en = 1'b0;
        run_test(0, 1'b0, 13'sd561, 13'sd3278, 13'sd4095, 13'sd4095, 4'hF, 6, 1'b1);
        run_test(1, 1'b0, -13'sd562, -13'sd3279, -13'sd4096, -13'sd4096, 4'hF, 6, 1'b1);
        run_test(2, 1'b0, 13'sd0, 13'sd0, 13'sd0, 13'sd0, 4'h8, 6, 1'b1);
        run_test(0, 1'b1, 13'sd561, 13'sd3278, 13'sd4095, 13'sd4095, 4'hF, 5, 1'b1);
        // pending sample aborted by reset while the comb FSM sits in C2
        suppress = 1'b1;
        repeat (32) drive(1'b1, 1'b1);
        suppress = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_sample", int'(bus.sample_out), 0);
        check("midrst_strobe", int'(bus.sample_strobe), 0);
        bus.bit_en = 1'b0;
        repeat (3) @(negedge clk);
        clear_model();
        rst = 1'b0;
        repeat (40) drive(1'b0, 1'b0);
        check("post_rst_sample", int'(bus.sample_out), 0);
        run_test(0, 1'b0, 13'sd561, 13'sd3278, 13'sd4095, 13'sd4095, 4'hF, 5, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
